lsu_ctrl: RTL

- Memory-access control stage directly upstream of the DPI-backed Lsu.
- Accepts one load/store request from EXU per transaction over valid/ready.
- Drives Lsu ports: unshifted size mask, data pre-shifted into byte lanes, single-cycle write strobe.
- Sign/zero-extends load data; hands the result to WBU over valid/ready.
- Models configurable memory latency; checks alignment.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_ctrl_if.sv | 38 +++
 rtl/lsu_load_ext.sv | 21 ++
 rtl/lsu_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the lsu_ctrl memory-access stage.
package lsu_pkg;

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} size_e;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  function automatic logic [7:0] size_mask(size_e sz);
    case (sz)
      SZ_B:    return MASK_B;
      SZ_H:    return MASK_H;
      SZ_W:    return MASK_W;
      default: return MASK_D;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(size_e sz);
    case (sz)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// EXU request, Lsu memory and WBU response signals of lsu_ctrl.
interface lsu_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_ren;
  logic        in_wen;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic [1:0]  in_size;
  logic        in_signed;
  logic [4:0]  in_rd;
  logic [63:0] mem_raddr;
  logic [63:0] mem_rdata;
  logic        mem_wvalid;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_rdata;
  logic [4:0]  out_rd;
  logic        out_rf_wen;
  logic        out_misalign;

  modport slave (
    input  in_valid, in_ren, in_wen, in_addr, in_wdata, in_size, in_signed, in_rd,
           mem_rdata, out_ready,
    output in_ready, mem_raddr, mem_wvalid, mem_waddr, mem_wdata, mem_wmask,
           out_valid, out_rdata, out_rd, out_rf_wen, out_misalign
  );

  modport master (
    output in_valid, in_ren, in_wen, in_addr, in_wdata, in_size, in_signed, in_rd,
           mem_rdata, out_ready,
    input  in_ready, mem_raddr, mem_wvalid, mem_waddr, mem_wdata, mem_wmask,
           out_valid, out_rdata, out_rd, out_rf_wen, out_misalign
  );
endinterface

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of right-aligned load data by access size.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  size_e       size_i,
  input  logic        signed_i,
  output logic [63:0] result_o
);

  always_comb begin
    result_o = rdata_i;
    case (size_i)
      SZ_B:    result_o = {{56{signed_i & rdata_i[7]}},  rdata_i[7:0]};
      SZ_H:    result_o = {{48{signed_i & rdata_i[15]}}, rdata_i[15:0]};
      SZ_W:    result_o = {{32{signed_i & rdata_i[31]}}, rdata_i[31:0]};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of the Lsu. Build option LSU_CTRL_MISALIGN_CHK_EN.
// States: IDLE accept request | ACCESS wait MEM_LAT cycles on memory | RESP hold result for WBU.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input logic        clock,
  input logic        reset,
  lsu_ctrl_if.slave  bus
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ren_q, ren_d;
  logic        wen_q, wen_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  size_e       size_q, size_d;
  logic        signed_q, signed_d;
  logic [4:0]  rd_q, rd_d;
  logic [63:0] rdata_q, rdata_d;
  logic        rf_wen_q, rf_wen_d;
  logic        misalign_q, misalign_d;
  logic        misalign_in;
  logic [63:0] ext_rdata;

`ifdef LSU_CTRL_MISALIGN_CHK_EN
  assign misalign_in = (bus.in_ren | bus.in_wen) &&
                       ((bus.in_addr[2:0] & align_mask(size_e'(bus.in_size))) != 3'b000);
`else
  assign misalign_in = 1'b0;
`endif

  lsu_load_ext u_load_ext (
    .rdata_i  (bus.mem_rdata),
    .size_i   (size_q),
    .signed_i (signed_q),
    .result_o (ext_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ren_d      = ren_q;
    wen_d      = wen_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    signed_d   = signed_q;
    rd_d       = rd_q;
    rdata_d    = rdata_q;
    rf_wen_d   = rf_wen_q;
    misalign_d = misalign_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          ren_d      = bus.in_ren;
          wen_d      = bus.in_wen;
          addr_d     = bus.in_addr;
          wdata_d    = bus.in_wdata;
          size_d     = size_e'(bus.in_size);
          signed_d   = bus.in_signed;
          rd_d       = bus.in_rd;
          rdata_d    = '0;
          rf_wen_d   = 1'b0;
          misalign_d = misalign_in;
          cnt_d      = CNT_INIT;
          if (misalign_in || !(bus.in_ren || bus.in_wen)) state_d = RESP;
          else                                            state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          if (ren_q) begin
            rdata_d  = ext_rdata;
            rf_wen_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= SZ_B;
      signed_q   <= 1'b0;
      rd_q       <= '0;
      rdata_q    <= '0;
      rf_wen_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ren_q      <= ren_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      rd_q       <= rd_d;
      rdata_q    <= rdata_d;
      rf_wen_q   <= rf_wen_d;
      misalign_q <= misalign_d;
    end
  end

  // Reset gates the strobes combinationally so an abandoned access never fires.
  assign bus.in_ready     = (state_q == IDLE) && !reset;
  assign bus.out_valid    = (state_q == RESP) && !reset;
  assign bus.mem_wvalid   = (state_q == ACCESS) && (cnt_q == 4'd0) && wen_q && !reset;
  assign bus.mem_raddr    = addr_q;
  assign bus.mem_waddr    = addr_q;
  assign bus.mem_wdata    = wdata_q << {addr_q[2:0], 3'b000};
  assign bus.mem_wmask    = size_mask(size_q);
  assign bus.out_rdata    = rdata_q;
  assign bus.out_rd       = rd_q;
  assign bus.out_rf_wen   = rf_wen_q;
  assign bus.out_misalign = misalign_q;

endmodule
